kernel_mem_bridge: RTL and testbench
====================================

Name: kernel_mem_bridge

Overview:
Parametrised successor to the single-kernel, two-port scratchpad reload wrapper. It single-steps an HLS kernel with a one-cycle clock-enable pulse instead of a divided clock. After each step it services every active memory port of the kernel, NUM_PORTS in total, in fixed index order over one shared external read channel and one shared external write channel. It sits between the HLS kernel and the host memory interface, and adds run statistics and a configurable address shift.

Parameters:
NUM_PORTS, 2, number of kernel memory ports; legal range 1..8
ADDR_WID, 14, kernel word-address width
DATA_WID, 32, data width
BYTE_SHIFT, 2, left shift converting a word address to a byte offset

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-low reset
start  in  1  level; begins a run when sampled high in IDLE
read_base  in  64  byte base address for reads
write_base  in  64  byte base address for writes
read_size_input  in  64  size value copied to read_size_output and write_size
read_ready  in  1  read data valid / read complete
write_ready  in  1  write accepted
read_data  in  DATA_WID  read return data
read_enable  out  1  one-cycle read request
write_enable  out  1  one-cycle write request
read_addr  out  64  read byte address
write_addr  out  64  write byte address
read_size_output  out  64  read size
write_size  out  64  write size
write_data  out  DATA_WID  write data
done  out  1  run complete; level
k_start  out  1  kernel ap_start
k_step  out  1  kernel clock-enable; one kernel cycle per high cycle
k_done  in  1  kernel ap_done
k_ce  in  NUM_PORTS  per-port chip enable
k_we  in  NUM_PORTS  per-port write enable
k_addr  in  NUM_PORTS*ADDR_WID  port p occupies bits [p*ADDR_WID +: ADDR_WID]
k_d  in  NUM_PORTS*DATA_WID  per-port write data
k_q  out  NUM_PORTS*DATA_WID  per-port read data; registered
stat_steps  out  32  kernel steps this run
stat_reads  out  32  reads issued this run
stat_writes  out  32  writes issued this run

Behaviour:
- Reset (reset=0, asynchronous): every output and stat counter goes to 0, all k_q go to 0, the pending mask and done latch are cleared, and the state becomes IDLE. This applies mid-access as well; any outstanding host transaction is abandoned.
- All outputs are registered.
- States: IDLE, STEP, CAPTURE, SCAN, ISSUE_RD, WAIT_RD, ISSUE_WR, WAIT_WR, FINISH.
- IDLE:
  - start=1 clears the stats, sets k_start=1 and moves to STEP.
  - done holds its prior value until start=1 is sampled.
- STEP: k_step=1 for exactly one cycle, then CAPTURE. stat_steps increments.
- CAPTURE:
  - Latch pend=k_ce and latch k_we, k_addr, k_d for all ports.
  - Latch done_l=k_done.
  - Go to SCAN.
- SCAN:
  - pend==0 and done_l=1: go to FINISH.
  - pend==0 and done_l=0: go to STEP.
  - Otherwise select p = lowest set bit of pend. If we[p]=1 go to ISSUE_WR, else ISSUE_RD.
- ISSUE_RD:
  - read_enable=1 for one cycle.
  - read_addr = read_base + (addr[p] << BYTE_SHIFT), computed zero-extended in 64 bits with modulo-2^64 wrap.
  - read_size_output = read_size_input.
  - stat_reads increments; go to WAIT_RD.
- WAIT_RD:
  - read_enable=0.
  - On read_ready=1: k_q[p] <= read_data, clear pend[p], go to SCAN.
  - read_ready asserted during ISSUE_RD is ignored.
- ISSUE_WR / WAIT_WR: mirror of the read path.
  - write_addr = write_base + (addr[p] << BYTE_SHIFT).
  - write_data = d[p]; write_size = read_size_input.
  - stat_writes increments.
  - Completion on write_ready=1 in WAIT_WR.
- k_q[p] holds its value until the next read on port p. Writes never alter k_q.
- Ports active in the same step are serviced strictly in index order, so a read on port 1 observes a same-step write from port 0.
- Read and write requests are never outstanding simultaneously.
- FINISH: done=1, k_start=0, go to IDLE. The stats hold their values.
- start while not in IDLE is ignored. k_done is only sampled in CAPTURE.
- Latency:
  - A step with no access takes 3 cycles (STEP, CAPTURE, SCAN).
  - Each access adds 2 cycles plus the host wait cycles.
- Stat counters saturate at 0xFFFFFFFF.

Test Plan:
- Reset then start=1; kernel makes no accesses and k_done=1 on its 3rd step -> exactly 3 k_step pulses, each 3 cycles apart; done=1; stat_steps=3, stat_reads=0, stat_writes=0.
- NUM_PORTS=2; one step with port0 read at addr 5 and port1 read at addr 7; read_base=0x1000; read_ready returned 2 cycles after each request -> read_addr=0x1014 then 0x101C; k_q[0] and k_q[1] hold the returned data; stat_reads=2.
- Same step with port0 write (addr 3, data 0xAB) and port1 read at addr 3; host memory model present -> write issued first at write_base+12; k_q[1]=0xAB.
- NUM_PORTS=4; ports 3 and 1 active in one step -> port1 serviced before port3; no k_step until both complete.
- read_ready held high throughout, including during ISSUE_RD -> each read still takes exactly 2 cycles; no access is skipped.
- Drive reset=0 asynchronously while in WAIT_WR -> all outputs read 0 immediately; after release, state is IDLE and the next start runs a fresh run with stats starting from 0.

Source files
------------

// File: rtl/kernel_mem_bridge.sv
// Single-steps an HLS kernel with a clock-enable pulse, then services each active
// kernel memory port in index order over one shared host read and write channel.
module kernel_mem_bridge #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WID   = 14,
    parameter int DATA_WID   = 32,
    parameter int BYTE_SHIFT = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [63:0]                   read_base,
    input  logic [63:0]                   write_base,
    input  logic [63:0]                   read_size_input,
    input  logic                          read_ready,
    input  logic                          write_ready,
    input  logic [DATA_WID-1:0]           read_data,
    output logic                          read_enable,
    output logic                          write_enable,
    output logic [63:0]                   read_addr,
    output logic [63:0]                   write_addr,
    output logic [63:0]                   read_size_output,
    output logic [63:0]                   write_size,
    output logic [DATA_WID-1:0]           write_data,
    output logic                          done,
    output logic                          k_start,
    output logic                          k_step,
    input  logic                          k_done,
    input  logic [NUM_PORTS-1:0]          k_ce,
    input  logic [NUM_PORTS-1:0]          k_we,
    input  logic [NUM_PORTS*ADDR_WID-1:0] k_addr,
    input  logic [NUM_PORTS*DATA_WID-1:0] k_d,
    output logic [NUM_PORTS*DATA_WID-1:0] k_q,
    output logic [31:0]                   stat_steps,
    output logic [31:0]                   stat_reads,
    output logic [31:0]                   stat_writes
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [3:0] {
        IDLE, STEP, CAPTURE, SCAN, ISSUE_RD, WAIT_RD, ISSUE_WR, WAIT_WR, FINISH
    } state_t;

    state_t                state_r;
    logic [NUM_PORTS-1:0]  pend_r;
    logic [NUM_PORTS-1:0]  we_r;
    logic [ADDR_WID-1:0]   addr_r [NUM_PORTS];
    logic [DATA_WID-1:0]   d_r    [NUM_PORTS];
    logic [DATA_WID-1:0]   q_r    [NUM_PORTS];
    logic                  done_l_r;
    logic [PW-1:0]         sel_r;

    logic [NUM_PORTS-1:0]  mask_s;
    logic                  any_s;
    logic [PW-1:0]         first_s;
    logic                  dispatch_s;

    function automatic logic [PW-1:0] lowest_set(input logic [NUM_PORTS-1:0] m);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = m[i] ? PW'(i) : idx;
        end
        return idx;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    function automatic logic [63:0] byte_addr(input logic [63:0] base, input logic [ADDR_WID-1:0] a);
        return base + (64'(a) << BYTE_SHIFT);
    endfunction

    // Pending set seen by the dispatcher; a completing access already counts as retired.
    always_comb begin
        mask_s     = pend_r;
        dispatch_s = 1'b0;
        if (state_r == WAIT_RD) begin
            mask_s     = pend_r & ~(NUM_PORTS'(1'b1) << sel_r);
            dispatch_s = read_ready;
        end else if (state_r == WAIT_WR) begin
            mask_s     = pend_r & ~(NUM_PORTS'(1'b1) << sel_r);
            dispatch_s = write_ready;
        end else if (state_r == SCAN) begin
            mask_s     = pend_r;
            dispatch_s = 1'b1;
        end else begin
            mask_s     = pend_r;
            dispatch_s = 1'b0;
        end
        any_s   = |mask_s;
        first_s = lowest_set(mask_s);
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_kq
        assign k_q[p*DATA_WID +: DATA_WID] = q_r[p];
    end

    // Sequencer: step kernel, capture its port requests, then serve them one by one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r          <= IDLE;
            pend_r           <= '0;
            we_r             <= '0;
            done_l_r         <= 1'b0;
            sel_r            <= '0;
            read_enable      <= 1'b0;
            write_enable     <= 1'b0;
            read_addr        <= 64'd0;
            write_addr       <= 64'd0;
            read_size_output <= 64'd0;
            write_size       <= 64'd0;
            write_data       <= '0;
            done             <= 1'b0;
            k_start          <= 1'b0;
            k_step           <= 1'b0;
            stat_steps       <= 32'd0;
            stat_reads       <= 32'd0;
            stat_writes      <= 32'd0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                addr_r[p] <= '0;
                d_r[p]    <= '0;
                q_r[p]    <= '0;
            end
        end else begin
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            k_step       <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        done        <= 1'b0;
                        k_start     <= 1'b1;
                        k_step      <= 1'b1;
                        stat_steps  <= 32'd1;
                        stat_reads  <= 32'd0;
                        stat_writes <= 32'd0;
                        state_r     <= STEP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                STEP:     state_r <= CAPTURE;
                CAPTURE: begin
                    pend_r   <= k_ce;
                    we_r     <= k_we;
                    done_l_r <= k_done;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        addr_r[p] <= k_addr[p*ADDR_WID +: ADDR_WID];
                        d_r[p]    <= k_d[p*DATA_WID +: DATA_WID];
                    end
                    state_r <= SCAN;
                end
                SCAN:     state_r <= SCAN;
                ISSUE_RD: state_r <= WAIT_RD;
                WAIT_RD: begin
                    if (read_ready) begin
                        q_r[sel_r]    <= read_data;
                        pend_r[sel_r] <= 1'b0;
                    end else begin
                        state_r <= WAIT_RD;
                    end
                end
                ISSUE_WR: state_r <= WAIT_WR;
                WAIT_WR: begin
                    if (write_ready) begin
                        pend_r[sel_r] <= 1'b0;
                    end else begin
                        state_r <= WAIT_WR;
                    end
                end
                FINISH:   state_r <= IDLE;
                default:  state_r <= IDLE;
            endcase

            // Scan decision, also taken directly on completion so an access costs two cycles.
            if (dispatch_s) begin
                if (any_s) begin
                    sel_r <= first_s;
                    if (we_r[first_s]) begin
                        write_enable <= 1'b1;
                        write_addr   <= byte_addr(write_base, addr_r[first_s]);
                        write_data   <= d_r[first_s];
                        write_size   <= read_size_input;
                        stat_writes  <= sat_inc(stat_writes);
                        state_r      <= ISSUE_WR;
                    end else begin
                        read_enable      <= 1'b1;
                        read_addr        <= byte_addr(read_base, addr_r[first_s]);
                        read_size_output <= read_size_input;
                        stat_reads       <= sat_inc(stat_reads);
                        state_r          <= ISSUE_RD;
                    end
                end else if (done_l_r) begin
                    done    <= 1'b1;
                    k_start <= 1'b0;
                    state_r <= FINISH;
                end else begin
                    k_step     <= 1'b1;
                    stat_steps <= sat_inc(stat_steps);
                    state_r    <= STEP;
                end
            end
        end
    end
endmodule

// File: tb/tb_kernel_mem_bridge.sv
// Directed bench for kernel_mem_bridge: scripted kernel, host memory, and a
// transaction-order model derived from the kernel script.
module tb_kernel_mem_bridge;
    localparam int NP = 4, AW = 14, DW = 32, BS = 2, MAXS = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [63:0] read_base = 64'h1000, write_base = 64'h2000, read_size_input = 64'h40;
    logic read_ready = 1'b0, write_ready = 1'b0;
    logic [DW-1:0] read_data = '0;
    logic read_enable, write_enable, done, k_start, k_step;
    logic [63:0] read_addr, write_addr, read_size_output, write_size;
    logic [DW-1:0] write_data;
    logic k_done = 1'b0;
    logic [NP-1:0] k_ce = '0, k_we = '0;
    logic [NP*AW-1:0] k_addr = '0;
    logic [NP*DW-1:0] k_d = '0;
    logic [NP*DW-1:0] k_q;
    logic [31:0] stat_steps, stat_reads, stat_writes;

    kernel_mem_bridge #(.NUM_PORTS(NP), .ADDR_WID(AW), .DATA_WID(DW), .BYTE_SHIFT(BS)) dut (
        .clk(clk), .reset(reset), .start(start), .read_base(read_base), .write_base(write_base),
        .read_size_input(read_size_input), .read_ready(read_ready), .write_ready(write_ready),
        .read_data(read_data), .read_enable(read_enable), .write_enable(write_enable),
        .read_addr(read_addr), .write_addr(write_addr), .read_size_output(read_size_output),
        .write_size(write_size), .write_data(write_data), .done(done), .k_start(k_start),
        .k_step(k_step), .k_done(k_done), .k_ce(k_ce), .k_we(k_we), .k_addr(k_addr), .k_d(k_d),
        .k_q(k_q), .stat_steps(stat_steps), .stat_reads(stat_reads), .stat_writes(stat_writes)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Kernel script: accesses presented after each step.
    logic [NP-1:0] t_ce [MAXS];
    logic [NP-1:0] t_we [MAXS];
    logic [AW-1:0] t_addr [MAXS][NP];
    logic [DW-1:0] t_d [MAXS][NP];
    logic t_done [MAXS];
    int n_steps;
    int ks = 0;

    task automatic clear_table();
        for (int s = 0; s < MAXS; s++) begin
            t_ce[s] = '0; t_we[s] = '0; t_done[s] = 1'b0;
            for (int p = 0; p < NP; p++) begin t_addr[s][p] = '0; t_d[s][p] = '0; end
        end
    endtask

    task automatic set_acc(input int s, input int p, input bit wr, input int a, input logic [DW-1:0] d);
        t_ce[s][p] = 1'b1; t_we[s][p] = wr; t_addr[s][p] = AW'(a); t_d[s][p] = d;
    endtask

    always @(negedge clk) begin
        if (reset && k_step) begin
            ks = ks + 1;
            if (ks <= MAXS) begin
                k_ce = t_ce[ks-1]; k_we = t_we[ks-1]; k_done = t_done[ks-1];
                for (int p = 0; p < NP; p++) begin
                    k_addr[p*AW +: AW] = t_addr[ks-1][p];
                    k_d[p*DW +: DW]    = t_d[ks-1][p];
                end
            end
        end
    end

    // Host memory with programmable response latency.
    logic [DW-1:0] mem [logic [63:0]];
    int rd_cnt = -1, wr_cnt = -1, rd_lat = 2, wr_lat = 2;
    bit hold_rr = 1'b0;
    logic [63:0] rd_a = 64'd0;

    always @(negedge clk) begin
        if (reset) begin
            if (read_enable) begin rd_cnt = rd_lat; rd_a = read_addr; end
            if (rd_cnt == 0) begin
                read_ready = 1'b1;
                read_data = mem.exists(rd_a) ? mem[rd_a] : '0;
                rd_cnt = -1;
            end else begin
                read_ready = hold_rr;
                if (rd_cnt > 0) rd_cnt--;
            end
            if (write_enable) begin mem[write_addr] = write_data; wr_cnt = wr_lat; end
            if (wr_cnt == 0) begin
                write_ready = 1'b1; wr_cnt = -1;
            end else begin
                write_ready = 1'b0;
                if (wr_cnt > 0) wr_cnt--;
            end
        end
    end

    // Model: ordered list of host transactions implied by the script.
    typedef struct {bit wr; int port; int tag; logic [63:0] addr; logic [DW-1:0] data;} exp_t;
    exp_t eq[$];
    exp_t ce;
    logic [DW-1:0] exp_mem [logic [63:0]];
    logic [DW-1:0] exp_kq [NP];
    int exp_nr, exp_nw;

    task automatic build_model();
        eq.delete(); exp_nr = 0; exp_nw = 0;
        for (int s = 0; s < n_steps; s++)
            for (int p = 0; p < NP; p++)
                if (t_ce[s][p]) begin
                    exp_t e;
                    e.wr = t_we[s][p]; e.port = p; e.tag = s + 1; e.data = t_d[s][p];
                    e.addr = (e.wr ? write_base : read_base) + (64'(t_addr[s][p]) * 64'd4);
                    eq.push_back(e);
                    if (e.wr) exp_nw++; else exp_nr++;
                end
    endtask

    task automatic preload(input logic [63:0] a, input logic [DW-1:0] v);
        mem[a] = v; exp_mem[a] = v;
    endtask

    int cyc = 0, pulses = 0;
    int ks_cyc[$];
    logic [63:0] obs_r[$], obs_w[$];
    logic prev_re = 1'b0, prev_we = 1'b0, prev_ks = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        chk("rw_excl", 64'(read_enable & write_enable), 64'd0);
        if (read_enable) begin
            chk("re_pulse", 64'(prev_re), 64'd0);
            chk("rd_expected", 64'(eq.size() != 0), 64'd1);
            if (eq.size() != 0) begin
                ce = eq.pop_front();
                chk("rd_kind", 64'(ce.wr), 64'd0);
                chk("rd_addr", read_addr, ce.addr);
                chk("rd_size", read_size_output, read_size_input);
                exp_kq[ce.port] = exp_mem.exists(ce.addr) ? exp_mem[ce.addr] : '0;
            end
            obs_r.push_back(read_addr);
        end
        if (write_enable) begin
            chk("we_pulse", 64'(prev_we), 64'd0);
            chk("wr_expected", 64'(eq.size() != 0), 64'd1);
            if (eq.size() != 0) begin
                ce = eq.pop_front();
                chk("wr_kind", 64'(ce.wr), 64'd1);
                chk("wr_addr", write_addr, ce.addr);
                chk("wr_data", 64'(write_data), 64'(ce.data));
                chk("wr_size", write_size, read_size_input);
                exp_mem[ce.addr] = ce.data;
            end
            obs_w.push_back(write_addr);
        end
        if (k_step) begin
            pulses++;
            chk("ks_pulse", 64'(prev_ks), 64'd0);
            chk("ks_order", 64'(eq.size() == 0 || eq[0].tag >= pulses), 64'd1);
            ks_cyc.push_back(cyc);
        end
        prev_re = read_enable; prev_we = write_enable; prev_ks = k_step;
    end

    task automatic start_run();
        ks = 0; k_ce = '0; k_we = '0; k_addr = '0; k_d = '0; k_done = 1'b0;
        build_model();
        pulses = 0; ks_cyc.delete(); obs_r.delete(); obs_w.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic finish_run();
        int n = 0;
        while (!done && n < 3000) begin @(negedge clk); n++; end
        chk("done_reached", 64'(done), 64'd1);
        chk("k_start_low", 64'(k_start), 64'd0);
        chk("queue_drained", 64'(eq.size()), 64'd0);
        chk("stat_steps", 64'(stat_steps), 64'(n_steps));
        chk("stat_reads", 64'(stat_reads), 64'(exp_nr));
        chk("stat_writes", 64'(stat_writes), 64'(exp_nw));
        for (int p = 0; p < NP; p++) chk($sformatf("kq%0d", p), 64'(k_q[p*DW +: DW]), 64'(exp_kq[p]));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_re"}, 64'(read_enable), 64'd0);
        chk({tag, "_we"}, 64'(write_enable), 64'd0);
        chk({tag, "_raddr"}, read_addr, 64'd0);
        chk({tag, "_waddr"}, write_addr, 64'd0);
        chk({tag, "_rsize"}, read_size_output, 64'd0);
        chk({tag, "_wsize"}, write_size, 64'd0);
        chk({tag, "_wdata"}, 64'(write_data), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_kstart"}, 64'(k_start), 64'd0);
        chk({tag, "_kstep"}, 64'(k_step), 64'd0);
        chk({tag, "_kq"}, 64'(|k_q), 64'd0);
        chk({tag, "_stats"}, 64'(stat_steps | stat_reads | stat_writes), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int p = 0; p < NP; p++) exp_kq[p] = '0;
        clear_table();
        #3 reset = 1'b0;
        #1 chk_zero("rst");
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // A: three steps, no accesses, kernel done on the third.
        clear_table(); n_steps = 3; t_done[2] = 1'b1;
        start_run(); finish_run();
        chk("a_steps_lit", 64'(stat_steps), 64'd3);
        chk("a_pulses", 64'(ks_cyc.size()), 64'd3);
        if (ks_cyc.size() == 3) begin
            chk("a_gap1", 64'(ks_cyc[1] - ks_cyc[0]), 64'd3);
            chk("a_gap2", 64'(ks_cyc[2] - ks_cyc[1]), 64'd3);
        end

        // B: two reads in one step, host latency 2.
        clear_table(); n_steps = 1; t_done[0] = 1'b1;
        set_acc(0, 0, 1'b0, 5, '0); set_acc(0, 1, 1'b0, 7, '0);
        preload(64'h1014, 32'hA1A1_A1A1); preload(64'h101C, 32'hB2B2_B2B2);
        start_run(); finish_run();
        chk("b_nreads", 64'(obs_r.size()), 64'd2);
        if (obs_r.size() == 2) begin
            chk("b_addr0", obs_r[0], 64'h1014);
            chk("b_addr1", obs_r[1], 64'h101C);
        end
        chk("b_kq0_lit", 64'(k_q[DW-1:0]), 64'hA1A1_A1A1);
        chk("b_kq1_lit", 64'(k_q[2*DW-1:DW]), 64'hB2B2_B2B2);
        chk("b_reads_lit", 64'(stat_reads), 64'd2);

        // C: port0 write then port1 read of the same word.
        write_base = 64'h1000;
        clear_table(); n_steps = 1; t_done[0] = 1'b1;
        set_acc(0, 0, 1'b1, 3, 32'hAB); set_acc(0, 1, 1'b0, 3, '0);
        start_run(); finish_run();
        chk("c_nwrites", 64'(obs_w.size()), 64'd1);
        if (obs_w.size() == 1) chk("c_waddr", obs_w[0], 64'h100C);
        chk("c_kq1_lit", 64'(k_q[2*DW-1:DW]), 64'hAB);
        chk("c_kq0_kept", 64'(k_q[DW-1:0]), 64'hA1A1_A1A1);

        // D: ports 3 and 1 active; port 1 first, next step only after both.
        clear_table(); n_steps = 2; t_done[1] = 1'b1;
        set_acc(0, 3, 1'b0, 9, '0); set_acc(0, 1, 1'b0, 4, '0);
        preload(64'h1024, 32'h3333_0003); preload(64'h1010, 32'h1111_0001);
        start_run(); finish_run();
        chk("d_nreads", 64'(obs_r.size()), 64'd2);
        if (obs_r.size() == 2) begin
            chk("d_first", obs_r[0], 64'h1010);
            chk("d_second", obs_r[1], 64'h1024);
        end
        chk("d_kq3_lit", 64'(k_q[4*DW-1:3*DW]), 64'h3333_0003);

        // E: read_ready held high; every read costs exactly two cycles.
        hold_rr = 1'b1; rd_lat = 1;
        clear_table(); n_steps = 2; t_done[1] = 1'b1;
        set_acc(0, 0, 1'b0, 1, '0); set_acc(0, 2, 1'b0, 2, '0);
        preload(64'h1004, 32'hE0E0_0001); preload(64'h1008, 32'hE0E0_0002);
        start_run(); finish_run();
        chk("e_nreads", 64'(obs_r.size()), 64'd2);
        if (ks_cyc.size() == 2) chk("e_gap", 64'(ks_cyc[1] - ks_cyc[0]), 64'd7);
        chk("e_kq2_lit", 64'(k_q[3*DW-1:2*DW]), 64'hE0E0_0002);
        hold_rr = 1'b0; rd_lat = 2;

        // F: asynchronous reset while a write waits for acceptance.
        wr_lat = 30;
        clear_table(); n_steps = 1; t_done[0] = 1'b1;
        set_acc(0, 0, 1'b1, 2, 32'h55);
        start_run();
        begin
            int n = 0;
            while (!write_enable && n < 50) begin @(negedge clk); n++; end
        end
        chk("f_write_seen", 64'(write_enable), 64'd1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_zero("f_rst");
        rd_cnt = -1; wr_cnt = -1; wr_lat = 2; write_ready = 1'b0; read_ready = 1'b0;
        eq.delete();
        for (int p = 0; p < NP; p++) exp_kq[p] = '0;
        @(negedge clk); reset = 1'b1;
        pulses = 0;
        repeat (5) @(negedge clk);
        chk("f_idle_pulses", 64'(pulses), 64'd0);
        chk("f_idle_kstart", 64'(k_start), 64'd0);
        clear_table(); n_steps = 1; t_done[0] = 1'b1;
        set_acc(0, 2, 1'b0, 5, '0);
        start_run(); finish_run();
        chk("f_steps_lit", 64'(stat_steps), 64'd1);
        chk("f_reads_lit", 64'(stat_reads), 64'd1);
        chk("f_writes_lit", 64'(stat_writes), 64'd0);
        chk("f_kq2_lit", 64'(k_q[3*DW-1:2*DW]), 64'hA1A1_A1A1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
